vram_scheduler: RTL and testbench
=================================

Name: vram_scheduler

Overview:
- Owns the single-port video RAM (VRAM) that holds a 160x120, 12-bit framebuffer.
- Feeds the VGA pixel path with color_data, pixel-aligned to the 640x480 display window; each stored pixel is replicated 4x horizontally and 4x vertically.
- Pixel fetches have absolute priority. CPU reads and writes use the remaining RAM port cycles through a req/ack handshake.
- Runs its own display timing counters, identical to the VGA timing generator and reset together with it, so alignment holds by construction.

Parameters:
H_SYNC, 96, horizontal sync width
H_BACK, 48, horizontal back porch
H_DATA, 640, active pixels per line
H_CYCLE, 800, line period
C_SYNC, 2, vertical sync lines
C_BACK, 29, vertical back porch
C_DATA, 480, active lines
C_CYCLE, 521, frame period
FB_W, 160, framebuffer width
FB_H, 120, framebuffer height
ADDR_W, 15, VRAM address width

Ports:
vga_clk  in  1  pixel clock; the only clock
sys_rst  in  1  reset, synchronous, active-high
ram_addr  out  15  VRAM address, registered
ram_we  out  1  VRAM write enable, registered
ram_wdata  out  12  VRAM write data, registered
ram_rdata  in  12  VRAM read data, valid the cycle after its address
color_data  out  12  pixel color to the VGA output stage, registered
cpu_req  in  1  CPU access request; held until cpu_ack
cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high
cpu_addr  in  15  CPU VRAM address
cpu_wdata  in  12  CPU write data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  12  read data, valid while cpu_ack is high
frame_start  out  1  high for the single cycle where h_cnt==0 and c_cnt==0
in_vblank  out  1  high while c_cnt<31 or c_cnt>=511

Behaviour:
- Counters:
  - h_cnt 0..799 wraps; c_cnt increments on h_cnt wrap and wraps 520->0.
  - Active window: h 144..783, c 31..510.
- Fetch slots:
  - Port cycles with c in 31..510 and h = 142+4k, k = 0..159.
  - ram_addr = fetch_addr, ram_we = 0.
  - color_data <= ram_rdata at the end of cycle h = 143+4k, so it is displayed for h = 144+4k .. 147+4k.
  - color_data <= 0 at the end of h = 783.
- Fetch address:
  - fetch_addr increments after each fetch.
  - At line end: if (c-31)[1:0] != 3, fetch_addr -= 160 (line repeated); otherwise keep the value.
  - fetch_addr <= 0 when c_cnt==0.
  - Range is 0..19199, with no multiplier.
- Port ownership:
  - Decided one cycle ahead, at the clock edge before the port cycle. Outputs are registered.
  - Non-fetch, non-CPU cycles: ram_we = 0, ram_addr holds its last value.
- CPU FSM: IDLE -> ISSUE -> ACK -> IDLE.
  - IDLE -> ISSUE at an edge where cpu_req=1 and the next cycle is not a fetch slot. cpu_addr, cpu_we and cpu_wdata are captured at that edge.
  - ISSUE: port carries the CPU operation; ram_we = cpu_we when cpu_addr < 19200.
  - ACK: cpu_ack = 1 for exactly one cycle. cpu_rdata = ram_rdata for a read, else holds its last value.
  - No new acceptance during ISSUE or ACK, so a req still high during ACK is not re-accepted.
- Out-of-range CPU address (>=19200):
  - Write is dropped (ram_we = 0) but still acked.
  - Read acks with cpu_rdata = 0.
- Latency:
  - Request to ack is 2 cycles when unobstructed.
  - Worst case is 3 cycles, when the cycle after the request is a fetch slot.
- Reset (sys_rst=1 at an edge):
  - Zeroes h_cnt, c_cnt, fetch_addr, color_data, ram_addr, ram_we, ram_wdata, cpu_ack and cpu_rdata.
  - FSM returns to IDLE.
  - A pending CPU access is abandoned and is never acked.

Decomposition:
- Package vram_pkg holds:
  - timing constants;
  - ACT_H0=144, ACT_V0=31, FETCH_H0=142;
  - FB_WORDS=19200;
  - the CPU FSM state enum.
- Sub-module vga_timing_gen produces h_cnt, c_cnt, frame_start and in_vblank. It is reusable by the VGA output stage.

Test Plan:
- Reset, then run to c=31, h=142 -> ram_addr=0 with ram_we=0 at that cycle. With RAM model mem[0]=0xF00, color_data=0xF00 for h=144..147 and 0 from h=784.
- Frame sweep -> rows 31..34 fetch 0..159, row 35 starts at 160, row 510 ends at 19199. The next frame restarts at 0, and frame_start pulses once per 416800 cycles.
- CPU write in vblank: req at c=0, h=200, addr 0x0123, data 0xABC -> ram_we=1 with addr 0x0123 / data 0xABC during h=201; cpu_ack at h=202 only; mem[0x123]=0xABC.
- Collision: req (write) at c=40, h=141 -> h=142 is a fetch of the correct address, CPU write at h=143, ack at h=144. The fetch is not disturbed.
- CPU read of mem[5]=0x3C7 -> ack with cpu_rdata=0x3C7. Read of addr 19200 -> ack with rdata 0. Write to 19200 -> ack, no ram_we.
- sys_rst=1 during ISSUE -> no cpu_ack ever, all outputs 0 the next cycle, counters restart at 0,0.

Source files
------------

// File: rtl/vram_pkg.sv
// Shared constants, CPU FSM state type and fetch-slot helper for the VRAM scheduler.
package vram_pkg;

  // Display timing (640x480 window inside an 800x521 raster)
  localparam int H_SYNC  = 96;
  localparam int H_BACK  = 48;
  localparam int H_DATA  = 640;
  localparam int H_CYCLE = 800;
  localparam int C_SYNC  = 2;
  localparam int C_BACK  = 29;
  localparam int C_DATA  = 480;
  localparam int C_CYCLE = 521;

  localparam int H_W = 10;
  localparam int C_W = 10;

  // Framebuffer geometry
  localparam int FB_W     = 160;
  localparam int FB_H     = 120;
  localparam int FB_WORDS = FB_W * FB_H;
  localparam int ADDR_W   = 15;
  localparam int PIX_W    = 12;

  // Active window and fetch slot placement
  localparam int ACT_H0   = H_SYNC + H_BACK;
  localparam int ACT_H1   = ACT_H0 + H_DATA - 1;
  localparam int ACT_V0   = C_SYNC + C_BACK;
  localparam int ACT_V1   = ACT_V0 + C_DATA - 1;
  localparam int FETCH_H0 = ACT_H0 - 2;
  localparam int FETCH_H1 = FETCH_H0 + 4 * (FB_W - 1);

  typedef enum logic [1:0] {
    CPU_IDLE  = 2'd0,
    CPU_ISSUE = 2'd1,
    CPU_ACK   = 2'd2
  } cpu_state_e;

  // True when the cycle after (h, c) is a pixel fetch slot. The slot never
  // straddles a line boundary, so the line number is unchanged.
  function automatic logic fetch_issue(input logic [H_W-1:0] h, input logic [C_W-1:0] c);
    return (c >= C_W'(ACT_V0)) && (c <= C_W'(ACT_V1)) &&
           (h >= H_W'(FETCH_H0 - 1)) && (h <= H_W'(FETCH_H1 - 1)) &&
           (h[1:0] == 2'((FETCH_H0 - 1) % 4));
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical raster counters with frame-start and vertical-blank flags.
module vga_timing_gen
  import vram_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  output logic [H_W-1:0] h_cnt,
  output logic [C_W-1:0] c_cnt,
  output logic           frame_start,
  output logic           in_vblank
);

  logic [H_W-1:0] h_d, h_q;
  logic [C_W-1:0] c_d, c_q;

  // Next raster position: h wraps every line, c advances on h wrap
  always_comb begin
    h_d = h_q + H_W'(1);
    c_d = c_q;
    if (h_q == H_W'(H_CYCLE - 1)) begin
      h_d = '0;
      c_d = (c_q == C_W'(C_CYCLE - 1)) ? '0 : c_q + C_W'(1);
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      h_q <= '0;
      c_q <= '0;
    end else begin
      h_q <= h_d;
      c_q <= c_d;
    end
  end

  assign h_cnt       = h_q;
  assign c_cnt       = c_q;
  assign frame_start = (h_q == '0) && (c_q == '0);
  assign in_vblank   = (c_q < C_W'(ACT_V0)) || (c_q > C_W'(ACT_V1));

endmodule

// File: rtl/vram_scheduler.sv
// Single-port VRAM arbiter: pixel fetches own fixed slots, the CPU gets the rest.
module vram_scheduler
  import vram_pkg::*;
(
  input  logic              vga_clk,
  input  logic              sys_rst,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [PIX_W-1:0]  ram_wdata,
  input  logic [PIX_W-1:0]  ram_rdata,
  output logic [PIX_W-1:0]  color_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [PIX_W-1:0]  cpu_wdata,
  output logic              cpu_ack,
  output logic [PIX_W-1:0]  cpu_rdata,
  output logic              frame_start,
  output logic              in_vblank
);

  logic [H_W-1:0] h_cnt;
  logic [C_W-1:0] c_cnt;

  vga_timing_gen u_timing (
    .clk         (vga_clk),
    .rst         (sys_rst),
    .h_cnt       (h_cnt),
    .c_cnt       (c_cnt),
    .frame_start (frame_start),
    .in_vblank   (in_vblank)
  );

  cpu_state_e state_q;
  logic       cpu_ack_q;
  logic       op_rd_q;
  logic       op_oor_q;

  logic [ADDR_W-1:0] fetch_addr_d, fetch_addr_q;
  logic [ADDR_W-1:0] ram_addr_d, ram_addr_q;
  logic              ram_we_d, ram_we_q;
  logic [PIX_W-1:0]  ram_wdata_d, ram_wdata_q;
  logic [PIX_W-1:0]  color_d, color_q;
  logic [PIX_W-1:0]  rdata_d, rdata_q;

  logic       line_active;
  logic       fetch_next;
  logic       cpu_in_range;
  logic       accept;
  logic [1:0] row_phase;

  // Slot decisions are made for the following cycle so the port is registered
  always_comb begin
    line_active  = (c_cnt >= C_W'(ACT_V0)) && (c_cnt <= C_W'(ACT_V1));
    fetch_next   = fetch_issue(h_cnt, c_cnt);
    cpu_in_range = cpu_addr < ADDR_W'(FB_WORDS);
    accept       = (state_q == CPU_IDLE) && cpu_req && !fetch_next;
    // (c - ACT_V0) mod 4: the fourth copy of a stored row moves on to the next row
    row_phase    = c_cnt[1:0] - 2'(ACT_V0 % 4);
  end

  // Fetch address walks one stored row per displayed line, rewinding for repeats
  always_comb begin
    fetch_addr_d = fetch_addr_q;
    if (c_cnt == '0) begin
      fetch_addr_d = '0;
    end else if (fetch_next) begin
      fetch_addr_d = fetch_addr_q + ADDR_W'(1);
    end else if (line_active && (h_cnt == H_W'(ACT_H1)) && (row_phase != 2'd3)) begin
      fetch_addr_d = fetch_addr_q - ADDR_W'(FB_W);
    end
  end

  // RAM port mux: fetch wins, otherwise an accepted CPU operation, otherwise idle
  always_comb begin
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
    if (fetch_next) begin
      ram_addr_d = fetch_addr_q;
    end else if (accept) begin
      ram_addr_d  = cpu_addr;
      ram_we_d    = cpu_we && cpu_in_range;
      ram_wdata_d = cpu_wdata;
    end
  end

  // Pixel latch one cycle after each fetch; blank after the last active pixel
  always_comb begin
    color_d = color_q;
    if (line_active && (h_cnt >= H_W'(FETCH_H0 + 1)) && (h_cnt <= H_W'(FETCH_H1 + 1)) &&
        (h_cnt[1:0] == 2'((FETCH_H0 + 1) % 4))) begin
      color_d = ram_rdata;
    end else if (h_cnt == H_W'(ACT_H1)) begin
      color_d = '0;
    end
  end

  // CPU read data is live from the RAM during the ack cycle, held afterwards
  always_comb begin
    rdata_d = rdata_q;
    if ((state_q == CPU_ACK) && op_rd_q) begin
      rdata_d = op_oor_q ? '0 : ram_rdata;
    end
  end

  // Datapath registers
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      fetch_addr_q <= '0;
      ram_addr_q   <= '0;
      ram_we_q     <= 1'b0;
      ram_wdata_q  <= '0;
      color_q      <= '0;
      rdata_q      <= '0;
    end else begin
      fetch_addr_q <= fetch_addr_d;
      ram_addr_q   <= ram_addr_d;
      ram_we_q     <= ram_we_d;
      ram_wdata_q  <= ram_wdata_d;
      color_q      <= color_d;
      rdata_q      <= rdata_d;
    end
  end

  // CPU access FSM: IDLE -> ISSUE (port cycle) -> ACK (one-cycle pulse) -> IDLE
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      state_q   <= CPU_IDLE;
      cpu_ack_q <= 1'b0;
      op_rd_q   <= 1'b0;
      op_oor_q  <= 1'b0;
    end else begin
      case (state_q)
        CPU_IDLE: begin
          cpu_ack_q <= 1'b0;
          if (accept) begin
            state_q  <= CPU_ISSUE;
            op_rd_q  <= !cpu_we;
            op_oor_q <= !cpu_in_range;
          end
        end
        CPU_ISSUE: begin
          state_q   <= CPU_ACK;
          cpu_ack_q <= 1'b1;
        end
        CPU_ACK: begin
          state_q   <= CPU_IDLE;
          cpu_ack_q <= 1'b0;
        end
        default: begin
          state_q   <= CPU_IDLE;
          cpu_ack_q <= 1'b0;
        end
      endcase
    end
  end

  assign ram_addr   = ram_addr_q;
  assign ram_we     = ram_we_q;
  assign ram_wdata  = ram_wdata_q;
  assign color_data = color_q;
  assign cpu_ack    = cpu_ack_q;
  assign cpu_rdata  = rdata_d;

endmodule

// File: tb/tb_vram_scheduler.sv
// Scoreboard bench for vram_scheduler: raster-level reference model plus queued CPU results.
module tb_vram_scheduler;

  logic        vga_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [14:0] ram_addr;
  logic        ram_we;
  logic [11:0] ram_wdata;
  logic [11:0] ram_rdata;
  logic [11:0] color_data;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [14:0] cpu_addr = '0;
  logic [11:0] cpu_wdata = '0;
  logic        cpu_ack;
  logic [11:0] cpu_rdata;
  logic        frame_start;
  logic        in_vblank;

  vram_scheduler dut (
    .vga_clk     (vga_clk),
    .sys_rst     (sys_rst),
    .ram_addr    (ram_addr),
    .ram_we      (ram_we),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .color_data  (color_data),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_ack     (cpu_ack),
    .cpu_rdata   (cpu_rdata),
    .frame_start (frame_start),
    .in_vblank   (in_vblank)
  );

  always #5 vga_clk = ~vga_clk;

  int checks = 0;
  int failures = 0;
  bit armed = 1'b0;

  logic [11:0] ram     [0:32767];
  logic [11:0] ref_mem [0:32767];
  logic [11:0] exp_q   [$];
  logic [11:0] last_rd = '0;

  int th = 0;
  int tc = 0;

  // Synchronous RAM: read data appears the cycle after its address
  always @(posedge vga_clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  // Reference raster position of the current cycle
  always @(posedge vga_clk) begin
    if (sys_rst) begin
      th <= 0;
      tc <= 0;
    end else if (th == 799) begin
      th <= 0;
      tc <= (tc == 520) ? 0 : tc + 1;
    end else begin
      th <= th + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (c=%0d h=%0d)", name, act, exp, tc, th);
    end
  endtask

  function automatic bit is_active(int h, int c);
    return (c >= 31) && (c <= 510) && (h >= 144) && (h <= 783);
  endfunction

  // Displayed pixel at (h, c): each stored pixel covers a 4x4 block of the window
  function automatic logic [11:0] exp_color(int h, int c);
    if (!is_active(h, c)) return 12'h000;
    return ref_mem[((c - 31) / 4) * 160 + (h - 144) / 4];
  endfunction

  function automatic bit is_fetch(int h, int c);
    return (c >= 31) && (c <= 510) && (h >= 142) && (h <= 778) && ((h - 142) % 4 == 0);
  endfunction

  function automatic bit next_is_fetch(int h, int c);
    int nh = h + 1;
    int nc = c;
    if (nh == 800) begin
      nh = 0;
      nc = (c == 520) ? 0 : c + 1;
    end
    return is_fetch(nh, nc);
  endfunction

  // Monitor: raster flags, pixels, fetch port and CPU acks against the model
  always @(negedge vga_clk) begin
    if (armed) begin
      chk("frame_start", 32'(frame_start), 32'(th == 0 && tc == 0));
      chk("in_vblank", 32'(in_vblank), 32'(tc < 31 || tc >= 511));
      chk("color_data", 32'(color_data), 32'(exp_color(th, tc)));
      if (is_fetch(th, tc)) begin
        chk("fetch_addr", 32'(ram_addr), 32'(((tc - 31) / 4) * 160 + (th - 142) / 4));
        chk("fetch_we", 32'(ram_we), 32'd0);
      end
      if (cpu_ack === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", 32'd1, 32'd0);
        end else begin
          chk("cpu_rdata", 32'(cpu_rdata), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic wait_until(input int c, input int h);
    int n = 0;
    while (!(tc == c && th == h)) begin
      @(negedge vga_clk);
      n++;
      if (n > 100000) begin
        $display("FAIL wait_until: position c=%0d h=%0d not reached", c, h);
        $fatal(1, "timeout");
      end
    end
  endtask

  // Issue one CPU access from the current cycle; expectations go to the scoreboard
  task automatic cpu_op(input logic we, input logic [14:0] addr, input logic [11:0] wd,
                        input bit hold);
    int exp_lat = next_is_fetch(th, tc) ? 3 : 2;
    int lat = 0;
    bit got = 1'b0;
    logic       p_we = 1'bx;
    logic [14:0] p_addr = 'x;
    logic [11:0] p_wd = 'x;
    bit in_range = (int'(addr) < 19200);
    if (!we) last_rd = in_range ? ref_mem[addr] : 12'h000;
    else if (in_range) ref_mem[addr] = wd;
    exp_q.push_back(last_rd);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    while (lat < 8 && !got) begin
      @(negedge vga_clk);
      lat++;
      if (cpu_ack === 1'b1) got = 1'b1;
      else begin p_we = ram_we; p_addr = ram_addr; p_wd = ram_wdata; end
    end
    chk("ack_seen", 32'(got), 32'd1);
    chk("ack_latency", 32'(lat), 32'(exp_lat));
    chk("issue_we", 32'(p_we), 32'(we && in_range));
    chk("issue_addr", 32'(p_addr), 32'(addr));
    if (we && in_range) chk("issue_wdata", 32'(p_wd), 32'(wd));
    if (hold) begin
      @(negedge vga_clk);
      cpu_req = 1'b0;
      repeat (4) begin
        @(negedge vga_clk);
        chk("no_reaccept", 32'(cpu_ack), 32'd0);
      end
    end else begin
      cpu_req = 1'b0;
    end
    @(negedge vga_clk);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    chk({tag, "_ram_we"}, 32'(ram_we), 32'd0);
    chk({tag, "_ram_wdata"}, 32'(ram_wdata), 32'd0);
    chk({tag, "_color"}, 32'(color_data), 32'd0);
    chk({tag, "_cpu_ack"}, 32'(cpu_ack), 32'd0);
    chk({tag, "_cpu_rdata"}, 32'(cpu_rdata), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) begin
      ram[i] = 12'($urandom);
      ref_mem[i] = ram[i];
    end
    ram[0] = 12'hF00; ref_mem[0] = 12'hF00;
    ram[5] = 12'h3C7; ref_mem[5] = 12'h3C7;

    sys_rst = 1'b1;
    repeat (3) @(negedge vga_clk);
    armed = 1'b1;
    chk_zero_outputs("reset");
    sys_rst = 1'b0;

    // Vertical blank: directed accesses then random traffic
    wait_until(0, 200);
    cpu_op(1'b1, 15'h0123, 12'hABC, 1'b0);
    cpu_op(1'b0, 15'h0123, 12'h000, 1'b0);
    cpu_op(1'b0, 15'd5, 12'h000, 1'b0);
    cpu_op(1'b0, 15'd19200, 12'h000, 1'b0);
    cpu_op(1'b1, 15'd19200, 12'h555, 1'b0);
    cpu_op(1'b1, 15'd19199, 12'h0F0, 1'b1);
    for (int i = 0; i < 30; i++) begin
      logic [14:0] a;
      bit w = bit'($urandom_range(0, 1));
      a = (($urandom_range(0, 7)) == 0) ? 15'($urandom_range(19200, 32767))
                                         : 15'($urandom_range(1, 19199));
      cpu_op(w, a, 12'($urandom), bit'($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 3)) @(negedge vga_clk);
    end

    // Active lines: collision with a fetch slot, then random traffic around fetches
    wait_until(40, 141);
    cpu_op(1'b1, 15'd19000, 12'h9A5, 1'b0);
    for (int i = 0; i < 25; i++) begin
      logic [14:0] a;
      bit w = bit'($urandom_range(0, 1));
      if (w) a = 15'($urandom_range(18000, 19199));
      else a = 15'($urandom_range(0, 19199));
      if ($urandom_range(0, 9) == 0) a = 15'($urandom_range(19200, 32767));
      cpu_op(w, a, 12'($urandom), 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge vga_clk);
    end

    // Reset while an access is in its port cycle: it must never be acked
    wait_until(45, 790);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'd5;
    @(negedge vga_clk);
    sys_rst = 1'b1;
    @(negedge vga_clk);
    chk_zero_outputs("midrst");
    chk("midrst_frame_start", 32'(frame_start), 32'd1);
    sys_rst = 1'b0;
    cpu_req = 1'b0;
    last_rd = 12'h000;
    repeat (6) begin
      @(negedge vga_clk);
      chk("abandoned_ack", 32'(cpu_ack), 32'd0);
    end

    wait_until(0, 300);
    cpu_op(1'b1, 15'd200, 12'h0CE, 1'b0);
    cpu_op(1'b0, 15'h0123, 12'h000, 1'b0);
    cpu_op(1'b1, 15'd19200, 12'hFFF, 1'b0);
    repeat (4) @(negedge vga_clk);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
